// File: rtl/ex_operand_stage_pkg.sv
// Shared constants for the ID/EX operand stage: ALU opcodes, RV32 major opcodes,
// funct3/funct7 fields, and the held pipeline packet.
package ex_operand_stage_pkg;

   // ALU / mul-div opcode space, shared with the downstream units
   localparam logic [4:0] ALU_ADD    = 5'd0;
   localparam logic [4:0] ALU_SUB    = 5'd1;
   localparam logic [4:0] ALU_OR     = 5'd2;
   localparam logic [4:0] ALU_AND    = 5'd3;
   localparam logic [4:0] ALU_XOR    = 5'd4;
   localparam logic [4:0] ALU_SLL    = 5'd5;
   localparam logic [4:0] ALU_SRL    = 5'd6;
   localparam logic [4:0] ALU_SRA    = 5'd7;
   localparam logic [4:0] ALU_SLT    = 5'd8;
   localparam logic [4:0] ALU_MUL    = 5'd9;
   localparam logic [4:0] ALU_MULH   = 5'd10;
   localparam logic [4:0] ALU_MULHSU = 5'd11;
   localparam logic [4:0] ALU_MULHU  = 5'd12;
   localparam logic [4:0] ALU_DIV    = 5'd13;
   localparam logic [4:0] ALU_DIVU   = 5'd14;
   localparam logic [4:0] ALU_REM    = 5'd15;
   localparam logic [4:0] ALU_REMU   = 5'd16;
   localparam logic [4:0] ALU_SLTU   = 5'd17;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;
   localparam logic [6:0] F7_MULDIV  = 7'b0000001;

   // OP / OP-IMM / M-extension funct3
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   // Branch funct3
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Load / store / JALR funct3
   localparam logic [2:0] F3_LB   = 3'b000;
   localparam logic [2:0] F3_LH   = 3'b001;
   localparam logic [2:0] F3_LW   = 3'b010;
   localparam logic [2:0] F3_LBU  = 3'b100;
   localparam logic [2:0] F3_LHU  = 3'b101;
   localparam logic [2:0] F3_SB   = 3'b000;
   localparam logic [2:0] F3_SH   = 3'b001;
   localparam logic [2:0] F3_SW   = 3'b010;
   localparam logic [2:0] F3_JALR = 3'b000;

   typedef struct packed {
      logic [31:0] rega;
      logic [31:0] regb;
      logic [4:0]  opcode;
      logic [4:0]  rd;
      logic        we;
      logic        illegal;
      logic [31:0] pc;
   } ex_pkt_t;

endpackage

// File: rtl/ex_operand_stage_imm_gen.sv
// Combinational RV32 immediate generator: every format decoded in parallel,
// each sign-extended to 32 bits.
module imm_gen (
   input  logic [31:0] instr,
   output logic [31:0] imm_i,
   output logic [31:0] imm_s,
   output logic [31:0] imm_b,
   output logic [31:0] imm_u,
   output logic [31:0] imm_j
);

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: decodes an RV32IM instruction into ALU operands/opcode
// and holds the result in a one-entry valid/ready register feeding the ALU.
module ex_operand_stage
   import ex_operand_stage_pkg::*;
#(
   parameter bit          EN_M     = 1'b1,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] alu_rega,
   output logic [31:0] alu_regb,
   output logic [4:0]  alu_opcode,
   output logic [4:0]  out_rd,
   output logic        out_we,
   output logic [31:0] out_pc,
   output logic        out_illegal
);

   logic [6:0]  opc;
   logic [4:0]  rd;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        unused_imm;

   assign opc = in_instr[6:0];
   assign rd  = in_instr[11:7];
   assign f3  = in_instr[14:12];
   assign f7  = in_instr[31:25];

   imm_gen u_imm_gen (
      .instr (in_instr),
      .imm_i (imm_i),
      .imm_s (imm_s),
      .imm_b (imm_b),
      .imm_u (imm_u),
      .imm_j (imm_j)
   );

   // B/J immediates belong to the branch unit; this stage only forwards link values
   assign unused_imm = ^{imm_b, imm_j};

   ex_pkt_t dec;
   logic    legal;
   logic    wr_class;

   always_comb begin
      dec      = '0;
      dec.rd   = rd;
      dec.pc   = in_pc;
      legal    = 1'b1;
      wr_class = 1'b0;
      case (opc)
         OPC_OP: begin
            dec.rega = rs1_data;
            dec.regb = rs2_data;
            wr_class = 1'b1;
            if (f7 == F7_BASE) begin
               case (f3)
                  F3_ADD:  dec.opcode = ALU_ADD;
                  F3_SLL:  dec.opcode = ALU_SLL;
                  F3_SLT:  dec.opcode = ALU_SLT;
                  F3_SLTU: dec.opcode = ALU_SLTU;
                  F3_XOR:  dec.opcode = ALU_XOR;
                  F3_SR:   dec.opcode = ALU_SRL;
                  F3_OR:   dec.opcode = ALU_OR;
                  default: dec.opcode = ALU_AND;
               endcase
            end else if (f7 == F7_ALT && f3 == F3_ADD) begin
               dec.opcode = ALU_SUB;
            end else if (f7 == F7_ALT && f3 == F3_SR) begin
               dec.opcode = ALU_SRA;
            end else if (f7 == F7_MULDIV && EN_M) begin
               case (f3)
                  3'd0:    dec.opcode = ALU_MUL;
                  3'd1:    dec.opcode = ALU_MULH;
                  3'd2:    dec.opcode = ALU_MULHSU;
                  3'd3:    dec.opcode = ALU_MULHU;
                  3'd4:    dec.opcode = ALU_DIV;
                  3'd5:    dec.opcode = ALU_DIVU;
                  3'd6:    dec.opcode = ALU_REM;
                  default: dec.opcode = ALU_REMU;
               endcase
            end else begin
               legal = 1'b0;
            end
         end
         OPC_OP_IMM: begin
            dec.rega = rs1_data;
            dec.regb = imm_i;
            wr_class = 1'b1;
            case (f3)
               F3_ADD:  dec.opcode = ALU_ADD;
               F3_SLT:  dec.opcode = ALU_SLT;
               F3_SLTU: dec.opcode = ALU_SLTU;
               F3_XOR:  dec.opcode = ALU_XOR;
               F3_OR:   dec.opcode = ALU_OR;
               F3_AND:  dec.opcode = ALU_AND;
               F3_SLL: begin
                  dec.regb   = {27'b0, in_instr[24:20]};
                  dec.opcode = ALU_SLL;
                  legal      = (f7 == F7_BASE);
               end
               default: begin
                  dec.regb   = {27'b0, in_instr[24:20]};
                  dec.opcode = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                  legal      = (f7 == F7_BASE) || (f7 == F7_ALT);
               end
            endcase
         end
         OPC_LUI: begin
            dec.regb = imm_u;
            wr_class = 1'b1;
         end
         OPC_AUIPC: begin
            dec.rega = in_pc;
            dec.regb = imm_u;
            wr_class = 1'b1;
         end
         OPC_LOAD: begin
            dec.rega = rs1_data;
            dec.regb = imm_i;
            wr_class = 1'b1;
            legal    = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                       (f3 == F3_LBU) || (f3 == F3_LHU);
         end
         OPC_STORE: begin
            dec.rega = rs1_data;
            dec.regb = imm_s;
            legal    = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
         end
         OPC_BRANCH: begin
            dec.rega = rs1_data;
            dec.regb = rs2_data;
            case (f3)
               F3_BEQ, F3_BNE:   dec.opcode = ALU_SUB;
               F3_BLT, F3_BGE:   dec.opcode = ALU_SLT;
               F3_BLTU, F3_BGEU: dec.opcode = ALU_SLTU;
               default:          legal = 1'b0;
            endcase
         end
         OPC_JAL: begin
            dec.rega = in_pc;
            dec.regb = 32'd4;
            wr_class = 1'b1;
         end
         OPC_JALR: begin
            dec.rega = in_pc;
            dec.regb = 32'd4;
            wr_class = 1'b1;
            legal    = (f3 == F3_JALR);
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         dec.rega   = '0;
         dec.regb   = '0;
         dec.opcode = ALU_ADD;
      end
      dec.illegal = !legal;
      dec.we      = wr_class && (rd != 5'd0) && legal;
   end

   ex_pkt_t pkt_d, pkt_q;
   logic    out_valid_d, out_valid_q;
   logic    capture;

   assign in_ready = !out_valid_q || out_ready;
   // flush discards the incoming word but leaves in_ready untouched
   assign capture  = in_valid && in_ready && !flush;

   always_comb begin
      pkt_d       = capture ? dec : pkt_q;
      out_valid_d = out_valid_q;
      if (flush)
         out_valid_d = 1'b0;
      else if (capture)
         out_valid_d = 1'b1;
      else if (out_ready)
         out_valid_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         pkt_q       <= '{pc: RESET_PC, default: '0};
      end else begin
         out_valid_q <= out_valid_d;
         pkt_q       <= pkt_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign alu_rega    = pkt_q.rega;
   assign alu_regb    = pkt_q.regb;
   assign alu_opcode  = pkt_q.opcode;
   assign out_rd      = pkt_q.rd;
   assign out_we      = pkt_q.we;
   assign out_pc      = pkt_q.pc;
   assign out_illegal = pkt_q.illegal;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: decode vectors, handshake, flush and
// asynchronous reset, with an EN_M=0 instance alongside for the M-extension gate.
module tb_ex_operand_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, flush, out_ready;
   logic [31:0] in_instr, in_pc, rs1_data, rs2_data;

   logic        in_ready, out_valid, out_we, out_illegal;
   logic [31:0] alu_rega, alu_regb, out_pc;
   logic [4:0]  alu_opcode, out_rd;

   logic        n_in_ready, n_out_valid, n_out_we, n_out_illegal;
   logic [31:0] n_alu_rega, n_alu_regb, n_out_pc;
   logic [4:0]  n_alu_opcode, n_out_rd;

   int vectors = 0;
   int miscompares = 0;

   localparam logic [31:0] RPC = 32'h8000_0000;

   always #5 clk = ~clk;

   ex_operand_stage #(.EN_M(1'b1), .RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .alu_rega(alu_rega), .alu_regb(alu_regb), .alu_opcode(alu_opcode),
      .out_rd(out_rd), .out_we(out_we), .out_pc(out_pc), .out_illegal(out_illegal)
   );

   ex_operand_stage #(.EN_M(1'b0)) dut_nom (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .flush(flush), .out_valid(n_out_valid), .out_ready(out_ready),
      .alu_rega(n_alu_rega), .alu_regb(n_alu_regb), .alu_opcode(n_alu_opcode),
      .out_rd(n_out_rd), .out_we(n_out_we), .out_pc(n_out_pc), .out_illegal(n_out_illegal)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b);
      in_valid = 1'b1;
      in_instr = instr;
      in_pc    = pc;
      rs1_data = a;
      rs2_data = b;
      tick();
   endtask

   task automatic chk_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] op, input logic we, input logic ill);
      chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
      chk({tag, ".rega"}, alu_rega, a);
      chk({tag, ".regb"}, alu_regb, b);
      chk({tag, ".opcode"}, {27'b0, alu_opcode}, {27'b0, op});
      chk({tag, ".we"}, {31'b0, out_we}, {31'b0, we});
      chk({tag, ".illegal"}, {31'b0, out_illegal}, {31'b0, ill});
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      in_instr = '0; in_pc = '0; rs1_data = '0; rs2_data = '0;
      #3;
      chk("rst.valid", {31'b0, out_valid}, 32'd0);
      chk("rst.rega", alu_rega, 32'd0);
      chk("rst.regb", alu_regb, 32'd0);
      chk("rst.opcode", {27'b0, alu_opcode}, 32'd0);
      chk("rst.rd", {27'b0, out_rd}, 32'd0);
      chk("rst.we", {31'b0, out_we}, 32'd0);
      chk("rst.illegal", {31'b0, out_illegal}, 32'd0);
      chk("rst.pc", out_pc, RPC);
      chk("rst.pc_nom", n_out_pc, 32'd0);
      chk("rst.in_ready", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // ADD x3,x1,x2
      issue(32'h002081B3, 32'h0000_0100, 32'd5, 32'd7);
      chk_out("add", 32'd5, 32'd7, 5'd0, 1'b1, 1'b0);
      chk("add.rd", {27'b0, out_rd}, 32'd3);
      chk("add.pc", out_pc, 32'h0000_0100);
      chk("add.nom_illegal", {31'b0, n_out_illegal}, 32'd0);

      // SRAI x5,x6,3 and the same word with a bad funct7
      issue(32'h40335293, 32'h0000_0104, 32'h8000_0000, 32'd0);
      chk_out("srai", 32'h8000_0000, 32'd3, 5'd7, 1'b1, 1'b0);
      chk("srai.rd", {27'b0, out_rd}, 32'd5);
      issue(32'h42335293, 32'h0000_0108, 32'h8000_0000, 32'd0);
      chk_out("srai_bad", 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);

      // MUL x1,x2,x3: M ops enabled vs disabled
      issue(32'h023100B3, 32'h0000_010C, 32'd6, 32'd7);
      chk_out("mul", 32'd6, 32'd7, 5'd9, 1'b1, 1'b0);
      chk("mul.nom_illegal", {31'b0, n_out_illegal}, 32'd1);
      chk("mul.nom_we", {31'b0, n_out_we}, 32'd0);

      issue(32'h40208233, 32'h0, 32'd9, 32'd4);          // SUB x4,x1,x2
      chk_out("sub", 32'd9, 32'd4, 5'd1, 1'b1, 1'b0);
      issue(32'hFFF00093, 32'h0, 32'd11, 32'd0);         // ADDI x1,x0,-1
      chk_out("addi", 32'd11, 32'hFFFF_FFFF, 5'd0, 1'b1, 1'b0);
      issue(32'h123453B7, 32'h0, 32'd1, 32'd2);          // LUI x7,0x12345
      chk_out("lui", 32'd0, 32'h1234_5000, 5'd0, 1'b1, 1'b0);
      issue(32'hFFFFF417, 32'h0000_0200, 32'd1, 32'd2);  // AUIPC x8,0xFFFFF
      chk_out("auipc", 32'h0000_0200, 32'hFFFF_F000, 5'd0, 1'b1, 1'b0);
      issue(32'h0080A283, 32'h0, 32'h1000, 32'd0);       // LW x5,8(x1)
      chk_out("lw", 32'h1000, 32'd8, 5'd0, 1'b1, 1'b0);
      issue(32'hFE20AE23, 32'h0, 32'h2000, 32'd3);       // SW x2,-4(x1)
      chk_out("sw", 32'h2000, 32'hFFFF_FFFC, 5'd0, 1'b0, 1'b0);
      issue(32'h0020E463, 32'h0, 32'd1, 32'd2);          // BLTU
      chk_out("bltu", 32'd1, 32'd2, 5'd17, 1'b0, 1'b0);
      issue(32'h0020C463, 32'h0, 32'd3, 32'd4);          // BLT
      chk_out("blt", 32'd3, 32'd4, 5'd8, 1'b0, 1'b0);
      issue(32'h000000EF, 32'h0000_0300, 32'd1, 32'd2);  // JAL x1,0
      chk_out("jal", 32'h0000_0300, 32'd4, 5'd0, 1'b1, 1'b0);
      issue(32'h00208033, 32'h0, 32'd1, 32'd2);          // ADD x0,x1,x2
      chk_out("add_x0", 32'd1, 32'd2, 5'd0, 1'b0, 1'b0);
      issue(32'h0000007F, 32'h0, 32'd1, 32'd2);          // unknown major opcode
      chk_out("bad_opc", 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);

      // Backpressure: held instruction stays put, next word waits
      issue(32'h002081B3, 32'h0000_0400, 32'd5, 32'd7);
      out_ready = 1'b0;
      in_instr  = 32'h40208233;
      rs1_data  = 32'd50;
      rs2_data  = 32'd20;
      #1;
      chk("bp.in_ready", {31'b0, in_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp.hold_valid", {31'b0, out_valid}, 32'd1);
         chk("bp.hold_rega", alu_rega, 32'd5);
         chk("bp.hold_opcode", {27'b0, alu_opcode}, 32'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp.in_ready_rel", {31'b0, in_ready}, 32'd1);
      tick();
      chk_out("bp.next", 32'd50, 32'd20, 5'd1, 1'b1, 1'b0);
      in_valid = 1'b0;
      tick();
      chk("drain.valid", {31'b0, out_valid}, 32'd0);

      // Flush beats capture
      issue(32'h002081B3, 32'h0000_0500, 32'd1, 32'd1);
      flush    = 1'b1;
      in_instr = 32'h40208233;
      #1;
      chk("flush.in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      chk("flush.valid", {31'b0, out_valid}, 32'd0);
      flush    = 1'b0;
      in_valid = 1'b0;
      tick();
      chk("flush.after", {31'b0, out_valid}, 32'd0);

      // Asynchronous reset mid-cycle
      issue(32'h002081B3, 32'h0000_0600, 32'd8, 32'd9);
      chk("arst.pre_valid", {31'b0, out_valid}, 32'd1);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("arst.valid", {31'b0, out_valid}, 32'd0);
      chk("arst.pc", out_pc, RPC);
      chk("arst.rega", alu_rega, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
ID/EX pipeline stage directly upstream of the RV32IM ALU and the mul/div unit.
- Decodes a 32-bit RV32IM instruction.
- Selects the two 32-bit ALU operands from register-file data, PC and immediates.
- Maps the instruction to the 5-bit ALU opcode.
- Holds the result in a one-entry valid/ready pipeline register that drives the ALU inputs directly.

Parameters:
EN_M, 1, 1 = decode M-extension (opcodes 9-16); 0 = M instructions flagged illegal
RESET_PC, 32'h0000_0000, reset value of out_pc

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high; one clock, no other reset
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept an instruction this cycle
in_instr  input  32  instruction word
in_pc  input  32  instruction PC
rs1_data  input  32  register-file read data for rs1 (already forwarded)
rs2_data  input  32  register-file read data for rs2 (already forwarded)
flush  input  1  kill the held and incoming instruction
out_valid  output  1  registered outputs hold a valid instruction
out_ready  input  1  downstream accepts the held instruction
alu_rega  output  32  ALU operand A
alu_regb  output  32  ALU operand B
alu_opcode  output  5  ALU opcode
out_rd  output  5  destination register
out_we  output  1  register write enable
out_pc  output  32  PC of the held instruction
out_illegal  output  1  unsupported or illegal encoding

Behaviour:
Reset:
- out_valid=0, alu_rega=0, alu_regb=0, alu_opcode=0, out_rd=0, out_we=0, out_illegal=0, out_pc=RESET_PC.
- Reset asserted mid-operation drops the held instruction immediately.

Handshake:
- in_ready = !out_valid || out_ready (combinational, no bubble).
- Capture when in_valid && in_ready. Latency is 1 cycle: instruction at edge N appears on outputs after edge N.
- out_valid: set on capture; cleared when out_ready && !capture.
- Output registers stay stable while out_valid && !out_ready.

Flush:
- Has priority over capture: out_valid=0 at the next edge and the incoming instruction is discarded.
- in_ready is unaffected by flush.

Opcode encoding (shared with the ALU and mul/div unit):
- ADD=0, SUB=1, OR=2, AND=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8.
- MUL=9, MULH=10, MULHSU=11, MULHU=12, DIV=13, DIVU=14, REM=15, REMU=16.
- SLTU=17.

Decode:
- OP (0110011): rega=rs1, regb=rs2. funct7=0100000 selects SUB/SRA. funct7=0000001 selects M ops 9-16 by funct3 when EN_M.
- OP-IMM (0010011): rega=rs1, regb=sign-extended I-immediate.
  - Shifts use regb={27'b0,shamt}.
  - SRAI requires funct7=0100000; SLLI/SRLI require 0000000.
- LUI: rega=0, regb={imm[31:12],12'b0}, ADD.
- AUIPC: rega=pc, regb=U-immediate, ADD.
- LOAD: rs1 + I-immediate, ADD.
- STORE: rs1 + S-immediate, ADD, out_we=0.
- BRANCH: rega=rs1, regb=rs2, out_we=0.
  - BEQ/BNE map to SUB (zero flag is used downstream).
  - BLT/BGE map to SLT.
  - BLTU/BGEU map to SLTU.
- JAL/JALR: rega=pc, regb=32'd4, ADD (link value).
- Any other encoding: out_illegal=1, alu_opcode=ADD, out_we=0, operands 0.
- out_we = writes-rd class && rd!=0 && !illegal.

Width rules:
- All immediates are sign-extended to 32 bits.
- No arithmetic is performed in this block.

Decomposition:
- Shared package/include holds:
  - ALU opcode localparams 0-17.
  - RV32 major-opcode constants.
  - funct3/funct7 constants.
- Sub-module imm_gen, purely combinational: instruction in, 32-bit I/S/B/U/J immediates out.
- Decode and the pipeline register stay in ex_operand_stage.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle: out_valid=1, rega=5, regb=7, opcode=0, out_rd=3, out_we=1.
- SRAI x5,x6,3 (0x40335293), rs1=0x8000_0000 -> opcode=7, rega=0x8000_0000, regb=3, out_we=1. Same word with funct7=0100001 -> out_illegal=1, out_we=0.
- MUL x1,x2,x3 (0x023100B3) -> opcode=9 with EN_M=1; out_illegal=1 with EN_M=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs unchanged; out_ready=1 -> next instruction captured the same edge.
- Flush with in_valid=1 and out_valid=1 -> out_valid=0 next cycle, incoming word not captured.
- rst asserted asynchronously mid-cycle with out_valid=1 -> out_valid=0 and out_pc=RESET_PC immediately, before the next clk edge.
